ofdm_cp_inserter: RTL and testbench
===================================

OFDM_CP_INSERTER -- requirements
Module: ofdm_cp_inserter

Interface
REQ-001 Parameter FFT_LEN, default 64: samples per frame received from the IFFT source port; power of two, 8..1024.
REQ-002 Parameter CP_LEN, default 16: cyclic-prefix length; 1..FFT_LEN-1.
REQ-003 The block SHALL run on one clock, with an asynchronous, active-low reset: clk and reset_n.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  IFFT source_valid.
REQ-007 in_ready  output  1  drives the IFFT source_ready.
REQ-008 in_sop  input  1  IFFT source_sop.
REQ-009 in_eop  input  1  IFFT source_eop.
REQ-010 in_real  input  8  IFFT source_real, two's complement.
REQ-011 in_imag  input  8  IFFT source_imag, two's complement.
REQ-012 in_exp  input  6  IFFT source_exp, block exponent.
REQ-013 in_error  input  2  IFFT source_error.
REQ-014 out_valid  output  1  output sample valid.
REQ-015 out_ready  input  1  downstream ready.
REQ-016 out_sop  output  1  first sample of the CP-extended symbol.
REQ-017 out_eop  output  1  last sample of the CP-extended symbol.
REQ-018 out_real, out_imag  output  8 each  sample data.
REQ-019 out_exp  output  6  block exponent of the current symbol.
REQ-020 frame_err  output  1  one-cycle pulse when an input frame is dropped.
REQ-021 sym_cnt  output  16  count of completed output symbols; wraps at 65535 to 0.

Function
REQ-022 Transfers SHALL occur on a rising edge only when valid and ready are both high, on either side.
REQ-023 States SHALL be FILL, PREFIX and BODY; in_ready = 1 only in FILL.
REQ-024 FILL SHALL behave as follows:
- Before a frame starts, accepted samples without in_sop are discarded.
- An accepted sample with in_sop starts a frame: it is written to buf[0], and in_exp is latched.
- The following samples are written to buf[1..FFT_LEN-1].
REQ-025 A frame SHALL be valid when in_eop coincides with write index FFT_LEN-1 and in_error = 0 was seen on every sample of the frame; a valid frame moves to PREFIX on the next edge.
REQ-026 The frame SHALL be dropped on any of these conditions:
- in_eop arrives early.
- Index FFT_LEN-1 is reached without in_eop.
- in_error != 0 on any sample.
- in_sop arrives mid-frame; this sample restarts the frame at buf[0].

On a drop, frame_err pulses for 1 cycle and the state stays in FILL.
REQ-027 PREFIX SHALL output buf[FFT_LEN-CP_LEN .. FFT_LEN-1] in order; out_sop = 1 on the first of these samples.
REQ-028 BODY SHALL output buf[0 .. FFT_LEN-1] in order; out_eop = 1 on the last of these samples.
REQ-029 out_valid SHALL rise on the first edge after the accepting edge of a valid in_eop, and SHALL stay high through PREFIX and BODY.
REQ-030 Each symbol SHALL be exactly FFT_LEN+CP_LEN output transfers, with no gaps while out_ready = 1.
REQ-031 While out_valid = 1 and out_ready = 0, all out_* signals SHALL hold stable.
REQ-032 out_exp SHALL equal the latched exponent for the whole symbol.
REQ-033 After the out_eop transfer the block SHALL behave as follows:
- It enters FILL.
- out_valid = 0 and in_ready = 1 from the next cycle.
- sym_cnt increments by 1.
REQ-034 No input SHALL be accepted during PREFIX or BODY, which gives back-pressure to the IFFT.
REQ-035 Addresses SHALL be log2(FFT_LEN) bits; the read address wraps from FFT_LEN-1 to 0 at the PREFIX->BODY boundary.

Reset
REQ-036 While reset_n = 0 the block SHALL hold all of the following at zero:
- state = FILL, with write/read indices = 0 and the frame-active flag = 0.
- out_valid, out_sop, out_eop, out_real, out_imag, out_exp, frame_err and sym_cnt = 0.
- in_ready = 0.

Buffer contents are not reset.
REQ-037 in_ready SHALL go to 1 on the first clk edge after reset_n deasserts.
REQ-038 Reset asserted mid-frame or mid-output SHALL abandon the symbol, and no partial symbol is emitted afterwards.

Verification
REQ-039 Frame of 64 samples with value n at index n, exp = 5, out_ready = 1 -> 80 outputs: 48..63 then 0..63, sop on the 48 sample, eop on the final 63, out_exp = 5 throughout, sym_cnt = 1.
REQ-040 Same frame with out_ready toggling 1/0 every cycle -> identical 80-sample sequence, outputs stable on stall cycles, in_ready = 0 until out_eop is accepted.
REQ-041 Frame with in_eop at index 40 -> frame_err pulses once, no output; the next correct frame is output normally.
REQ-042 in_error = 2'b01 on index 10 -> frame dropped, frame_err = 1 for one cycle, out_valid stays 0.
REQ-043 reset_n pulsed low during BODY at output index 30 -> all outputs 0 immediately, in_ready = 1 after release, no residual output.
REQ-044 Three back-to-back frames with a mid-frame in_sop in the 2nd -> 2 symbols output, 1 frame_err, sym_cnt = 2.

Source files
------------

// File: rtl/ofdm_cp_inserter.sv
// Purpose: buffers one IFFT frame, then replays its last CP_LEN samples followed by the whole frame.
// Latency: first output sample is registered one cycle after the eop of a valid frame is accepted.
// Backpressure: in_ready is low while a symbol is emitted; output registers hold while out_ready is low.
module ofdm_cp_inserter #(
   parameter int FFT_LEN = 64,
   parameter int CP_LEN  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic [7:0]  in_real,
   input  logic [7:0]  in_imag,
   input  logic [5:0]  in_exp,
   input  logic [1:0]  in_error,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic [7:0]  out_real,
   output logic [7:0]  out_imag,
   output logic [5:0]  out_exp,
   output logic        frame_err,
   output logic [15:0] sym_cnt
);

   localparam int AW = $clog2(FFT_LEN);
   localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);
   localparam logic [AW-1:0] CP_START = AW'(FFT_LEN - CP_LEN);

   typedef struct packed {
      logic [7:0] re;
      logic [7:0] im;
   } smp_t;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      PREFIX = 2'd1,
      BODY   = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   smp_t          sbuf [FFT_LEN];
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_idx;
   logic          active;
   logic          live;
   logic [5:0]    exp_q;

   logic          accept;
   logic          out_fire;
   logic          wr_en;
   logic          restart;
   logic          kill;
   logic          frame_ok;
   logic          load;
   logic          sym_done;

   // Input is only taken in FILL, and never in the cycle reset is still being left.
   assign in_ready = live && (state == FILL);

   // Next-state and per-cycle control: frame checking in FILL, output pacing in PREFIX/BODY.
   always_comb begin
      state_nxt = state;
      accept    = in_valid & in_ready;
      out_fire  = out_valid & out_ready;
      wr_en     = 1'b0;
      wr_addr   = in_sop ? '0 : wr_idx;
      restart   = 1'b0;
      kill      = 1'b0;
      frame_ok  = 1'b0;
      load      = 1'b0;
      sym_done  = 1'b0;
      case (state)
         FILL: begin
            // Samples arriving outside a frame without sop are simply ignored.
            if (accept && (in_sop || active)) begin
               wr_en   = 1'b1;
               restart = in_sop & active;
               if (in_error != 2'b00) begin
                  kill = 1'b1;
               end else if (in_eop) begin
                  if (wr_addr == LAST_IDX) begin
                     frame_ok = 1'b1;
                  end else begin
                     kill = 1'b1;
                  end
               end else if (wr_addr == LAST_IDX) begin
                  kill = 1'b1;
               end
               if (frame_ok) begin
                  state_nxt = PREFIX;
               end
            end
         end
         PREFIX: begin
            load = ~out_valid | out_ready;
            // rd_idx wraps to 0 naturally when the last prefix sample is loaded.
            if (load && (rd_idx == LAST_IDX)) begin
               state_nxt = BODY;
            end
         end
         BODY: begin
            // Once the eop sample sits in the output register, wait for it to be taken.
            load = ~out_eop & (~out_valid | out_ready);
            if (out_fire && out_eop) begin
               sym_done  = 1'b1;
               state_nxt = FILL;
            end
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame tracking: write index, frame-active flag, latched exponent and drop pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_idx    <= '0;
         active    <= 1'b0;
         exp_q     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= restart | kill;
         if (wr_en) begin
            if (kill || frame_ok) begin
               active <= 1'b0;
               wr_idx <= '0;
            end else begin
               active <= 1'b1;
               wr_idx <= wr_addr + AW'(1);
            end
            if (in_sop) begin
               exp_q <= in_exp;
            end
         end
      end
   end

   // Sample buffer; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         sbuf[wr_addr] <= {in_real, in_imag};
      end
   end

   // Output register stage, read pointer and completed-symbol counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live      <= 1'b0;
         rd_idx    <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
         out_exp   <= '0;
         sym_cnt   <= '0;
      end else begin
         live <= 1'b1;
         if (frame_ok) begin
            rd_idx <= CP_START;
         end else if (load) begin
            rd_idx <= rd_idx + AW'(1);
         end
         if (load) begin
            out_valid <= 1'b1;
            out_sop   <= (state == PREFIX) && (rd_idx == CP_START);
            out_eop   <= (state == BODY) && (rd_idx == LAST_IDX);
            out_real  <= sbuf[rd_idx].re;
            out_imag  <= sbuf[rd_idx].im;
            out_exp   <= exp_q;
         end else if (sym_done) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            sym_cnt   <= sym_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Purpose: directed checks of the cyclic-prefix inserter against hand-derived symbol sequences.
// Latency: one output sample per cycle when out_ready is held high.
// Backpressure: out_ready is either held high or toggled every cycle.
module tb_ofdm_cp_inserter;

   localparam int FFT = 64;
   localparam int CP  = 16;
   localparam int SYM = FFT + CP;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sop;
   logic        in_eop;
   logic [7:0]  in_real;
   logic [7:0]  in_imag;
   logic [5:0]  in_exp;
   logic [1:0]  in_error;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;
   logic [7:0]  out_real;
   logic [7:0]  out_imag;
   logic [5:0]  out_exp;
   logic        frame_err;
   logic [15:0] sym_cnt;

   always #5 clk = ~clk;

   ofdm_cp_inserter #(.FFT_LEN(FFT), .CP_LEN(CP)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .in_exp    (in_exp),
      .in_error  (in_error),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_exp   (out_exp),
      .frame_err (frame_err),
      .sym_cnt   (sym_cnt)
   );

   typedef struct {
      int         eop_idx;
      int         err_idx;
      bit         toggle;
      logic [5:0] e;
      int         n_out;
      int         n_err;
   } case_t;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   logic [23:0] exp_q[$];
   bit          mon_en     = 1'b0;
   bit          rdy_toggle = 1'b0;
   int          xfer_cnt = 0;
   int          err_cnt  = 0;
   int          vld_cnt  = 0;
   bit          held_vld = 1'b0;
   logic [23:0] held;
   logic [23:0] cur;
   int          exp_sym  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", name, act, req);
   endtask

   task automatic fail(input string name, input int act, input int req);
      chk_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
   endtask

   // Expected output word {re, im, sop, eop, exp}; frame sample n carries re = n, im = 255 - n.
   function automatic logic [23:0] mk(input int idx, input bit sop, input bit eop, input logic [5:0] e);
      logic [7:0] re;
      logic [7:0] im;
      re = 8'(idx);
      im = 8'(255 - idx);
      return {re, im, sop, eop, e};
   endfunction

   task automatic push_symbol(input logic [5:0] e);
      for (int k = 0; k < SYM; k++) begin
         int idx;
         idx = (k < CP) ? (FFT - CP + k) : (k - CP);
         exp_q.push_back(mk(idx, k == 0, k == SYM - 1, e));
      end
   endtask

   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input int eop_idx, input int err_idx, input logic [5:0] e);
      bit ok;
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_sop   = (i == 0);
         in_eop   = (i == eop_idx);
         in_real  = 8'(i);
         in_imag  = 8'(255 - i);
         in_exp   = e;
         in_error = (i == err_idx) ? 2'b01 : 2'b00;
         wait_accept(ok);
         if (!ok) begin
            fail("accept_timeout", i, n);
            break;
         end
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_error = 2'b00;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      repeat (4) @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
         if (exp_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!done) fail("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic run_case(input case_t tc, input int id);
      int x0;
      int e0;
      rdy_toggle = tc.toggle;
      x0 = xfer_cnt;
      e0 = err_cnt;
      if (tc.n_out == SYM) begin
         push_symbol(tc.e);
         exp_sym++;
      end
      send_frame(FFT, tc.eop_idx, tc.err_idx, tc.e);
      drain();
      check($sformatf("case%0d_outputs", id), xfer_cnt - x0, tc.n_out);
      check($sformatf("case%0d_frame_err", id), err_cnt - e0, tc.n_err);
      check($sformatf("case%0d_sym_cnt", id), sym_cnt, exp_sym);
   endtask

   // Output monitor: scoreboard compare on every transfer, hold check on every stall.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {out_real, out_imag, out_sop, out_eop, out_exp};
         if (frame_err) err_cnt++;
         if (out_valid) begin
            vld_cnt++;
            check("in_ready_during_output", in_ready, 1'b0);
         end
         if (held_vld) check("stall_hold", cur, held);
         held_vld = out_valid && !out_ready;
         held     = cur;
         if (out_valid && out_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) fail("unexpected_output", xfer_cnt, 0);
            else check($sformatf("sample_%0d", xfer_cnt - 1), cur, exp_q.pop_front());
         end
      end else begin
         held_vld = 1'b0;
      end
   end

   // Downstream ready: held high or toggled each cycle.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_toggle ? ~out_ready : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got 1, want 0");
      $fatal(1, "simulation time limit");
   end

   initial begin
      case_t cases[7];
      int    x0;
      int    e0;
      int    v0;
      bit    ok;

      cases[0] = '{63, -1, 1'b0, 6'd5,  SYM, 0};
      cases[1] = '{63, -1, 1'b1, 6'd5,  SYM, 0};
      cases[2] = '{40, -1, 1'b0, 6'd7,  0,   1};
      cases[3] = '{63, -1, 1'b0, 6'd12, SYM, 0};
      cases[4] = '{63, 10, 1'b0, 6'd3,  0,   1};
      cases[5] = '{-1, -1, 1'b0, 6'd4,  0,   1};
      cases[6] = '{63, -1, 1'b1, 6'd63, SYM, 0};

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_real  = '0;
      in_imag  = '0;
      in_exp   = '0;
      in_error = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_in_ready", in_ready, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_bus", {out_real, out_imag, out_sop, out_eop, out_exp}, 24'd0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_sym_cnt", sym_cnt, 16'd0);
      reset_n = 1'b1;
      #1;
      check("in_ready_before_edge", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check("in_ready_after_release", in_ready, 1'b1);
      mon_en = 1'b1;

      for (int c = 0; c < 7; c++) run_case(cases[c], c);

      // Back-to-back frames; the second is cut short by the sop of the third.
      rdy_toggle = 1'b0;
      x0 = xfer_cnt;
      e0 = err_cnt;
      push_symbol(6'd1);
      push_symbol(6'd3);
      exp_sym += 2;
      send_frame(FFT, 63, -1, 6'd1);
      send_frame(20, -1, -1, 6'd2);
      send_frame(FFT, 63, -1, 6'd3);
      drain();
      check("b2b_outputs", xfer_cnt - x0, 2 * SYM);
      check("b2b_frame_err", err_cnt - e0, 1);
      check("b2b_sym_cnt", sym_cnt, exp_sym);

      // Reset in the middle of the body, at body index 30.
      x0 = xfer_cnt;
      push_symbol(6'd9);
      send_frame(FFT, 63, -1, 6'd9);
      ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(posedge clk);
         #2;
         if (xfer_cnt - x0 >= CP + 30) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("mid_body_timeout", xfer_cnt - x0, CP + 30);
      check("mid_body_valid", out_valid, 1'b1);
      check("mid_body_real", out_real, 8'd30);
      reset_n = 1'b0;
      mon_en  = 1'b0;
      exp_q.delete();
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_bus", {out_real, out_imag, out_sop, out_eop, out_exp}, 24'd0);
      check("rst_sym_cnt", sym_cnt, 16'd0);
      check("rst_in_ready", in_ready, 1'b0);
      exp_sym = 0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      #1;
      check("rst_in_ready_before_edge", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check("rst_in_ready_after_release", in_ready, 1'b1);
      mon_en = 1'b1;
      v0 = vld_cnt;
      repeat (100) @(posedge clk);
      check("no_residual_output", vld_cnt - v0, 0);

      // Normal operation resumes after the abandoned symbol.
      x0 = xfer_cnt;
      push_symbol(6'd21);
      exp_sym = 1;
      send_frame(FFT, 63, -1, 6'd21);
      drain();
      check("recover_outputs", xfer_cnt - x0, SYM);
      check("recover_sym_cnt", sym_cnt, exp_sym);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
